// File: rtl/dibu_pkg.sv
// Shared constants and types for the instruction-fetch datapath.
package dibu_pkg;

  localparam int unsigned PC_W    = 9;
  localparam int unsigned INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_PC      = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] data;
  } ir_word_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: reads imem at the current PC and offers the word to decode,
// with flush-on-redirect, ack timeout and a sticky halt on errors.
module fetch_unit
  import dibu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               pc_err,
  output logic               pc_inc,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir_data,
  output logic [PC_W-1:0]    ir_pc,
  input  logic               ir_ready,
  input  logic               flush,
  output logic               halted,
  output logic [1:0]         err_code
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  fetch_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            drop_q, drop_d;
  ir_word_t        word_q, word_d;
  logic            req_d, valid_d, halted_d;
  logic [PC_W-1:0] addr_d;
  logic [1:0]      err_d;

  assign ir_data = word_q.data;
  assign ir_pc   = word_q.pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      word_q   <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      word_q   <= word_d;
      mem_req  <= req_d;
      mem_addr <= addr_d;
      ir_valid <= valid_d;
      halted   <= halted_d;
      err_code <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    word_d   = word_q;
    req_d    = mem_req;
    addr_d   = mem_addr;
    valid_d  = ir_valid;
    halted_d = halted;
    err_d    = err_code;
    pc_inc   = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        addr_d  = pc_in;
        cnt_d   = '0;
        req_d   = 1'b1;
      end
      REQ: begin
        if (mem_ack) begin
          req_d = 1'b0;
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            word_d  = '{pc: mem_addr, data: mem_rdata};
            valid_d = 1'b1;
            pc_inc  = 1'b1;
            state_d = HOLD;
          end
        end else if (cnt_q == CNT_LAST) begin
          req_d    = 1'b0;
          drop_d   = 1'b0;
          halted_d = 1'b1;
          err_d    = ERR_TIMEOUT;
          state_d  = HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // A request cannot be withdrawn; remember to discard its data.
          if (flush) drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (ir_ready && !flush) begin
          valid_d = 1'b0;
          addr_d  = pc_in;
          cnt_d   = '0;
          req_d   = 1'b1;
          state_d = REQ;
        end else if (flush) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      HALT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // PC-bank error wins over everything, including a same-cycle ack.
    if (pc_err && state_q != HALT) begin
      state_d  = HALT;
      err_d    = ERR_PC;
      halted_d = 1'b1;
      req_d    = 1'b0;
      valid_d  = 1'b0;
      drop_d   = 1'b0;
      word_d   = word_q;
      pc_inc   = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table-driven single fetches, directed corner sequences,
// and a scoreboard of expected instructions checked at each decode handshake.
module tb_fetch_unit;
  import dibu_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [PC_W-1:0]    pc_in;
  logic               pc_err = 1'b0;
  logic               pc_inc;
  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_ack = 1'b0;
  logic [INSTR_W-1:0] mem_rdata = '0;
  logic               ir_valid;
  logic [INSTR_W-1:0] ir_data;
  logic [PC_W-1:0]    ir_pc;
  logic               ir_ready = 1'b0;
  logic               flush = 1'b0;
  logic               halted;
  logic [1:0]         err_code;

  fetch_unit #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_err(pc_err), .pc_inc(pc_inc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc), .ir_ready(ir_ready),
    .flush(flush), .halted(halted), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // PC bank model: base plus the number of pc_inc pulses since the last rebase.
  logic [PC_W-1:0] pc_base = '0;
  logic            pc_auto = 1'b0;
  int              inc_total = 0;
  int              inc_base = 0;
  always @(posedge clk) if (pc_inc === 1'b1) inc_total <= inc_total + 1;
  assign pc_in = pc_auto ? PC_W'(32'(pc_base) + (inc_total - inc_base)) : pc_base;

  // Memory model: acks in REQ cycle mem_lat+1 when enabled.
  int   mem_lat = 0;
  logic mem_on = 1'b1;
  int   req_cyc = 0;
  always @(posedge clk) begin
    #1;
    if (mem_req === 1'b1 && mem_on) begin
      mem_ack = (req_cyc == mem_lat);
      if (req_cyc == mem_lat) mem_rdata = 16'hA5A5 ^ {7'b0, mem_addr};
      req_cyc++;
    end else begin
      mem_ack = 1'b0;
      req_cyc = 0;
    end
  end

  typedef struct {
    logic [PC_W-1:0]    pc;
    int                 lat;
    int                 exp_cyc;
    logic [INSTR_W-1:0] exp_data;
  } vec_t;

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] data;
  } exp_t;

  vec_t vecs[4];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // One clock; any decode handshake at that edge is checked against the scoreboard.
  task automatic step();
    logic            hs;
    logic [PC_W-1:0] p;
    logic [INSTR_W-1:0] d;
    exp_t e;
    hs = ir_valid && ir_ready && !flush && !rst && !pc_err;
    p  = ir_pc;
    d  = ir_data;
    @(posedge clk);
    #3;
    if (hs) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_handshake", 32'(p), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_ir_pc", 32'(p), 32'(e.pc));
        chk("sb_ir_data", 32'(d), 32'(e.data));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; pc_err = 1'b0; ir_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    inc_base = inc_total;
  endtask

  initial begin
    int  cyc;
    int  n;
    logic stable;

    vecs[0] = '{9'h000, 1, 3, 16'hA5A5};
    vecs[1] = '{9'h040, 0, 2, 16'hA5E5};
    vecs[2] = '{9'h1FF, 14, 16, 16'hA45A};
    vecs[3] = '{9'h123, 5, 7, 16'hA486};

    // Reset state
    pc_base = 9'h000; pc_auto = 1'b1; mem_on = 1'b1; mem_lat = 0;
    do_reset();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_ir_data", 32'(ir_data), 32'd0);
    chk("rst_ir_pc", 32'(ir_pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_err", 32'(err_code), 32'd0);

    // Table: single fetch, 5-cycle decode stall, then back-to-back refetch
    for (int i = 0; i < 4; i++) begin
      pc_base = vecs[i].pc; pc_auto = 1'b1; mem_on = 1'b1; mem_lat = vecs[i].lat;
      do_reset();
      step();
      chk("t_first_req", 32'(mem_req), 32'd1);
      chk("t_first_addr", 32'(mem_addr), 32'(vecs[i].pc));
      cyc = 1;
      while (!ir_valid && cyc < 40) begin
        step();
        cyc++;
      end
      chk("t_cycles_to_valid", 32'(cyc), 32'(vecs[i].exp_cyc));
      chk("t_ir_pc", 32'(ir_pc), 32'(vecs[i].pc));
      chk("t_ir_data", 32'(ir_data), 32'(vecs[i].exp_data));
      chk("t_inc_count", 32'(inc_total - inc_base), 32'd1);
      stable = 1'b1;
      for (int k = 0; k < 5; k++) begin
        step();
        stable &= (mem_req == 1'b0) && (ir_valid == 1'b1) && (pc_inc == 1'b0) &&
                  (ir_pc == vecs[i].pc) && (ir_data == vecs[i].exp_data);
      end
      chk("t_hold_stable", 32'(stable), 32'd1);
      chk("t_hold_inc_count", 32'(inc_total - inc_base), 32'd1);
      sb.push_back('{vecs[i].pc, vecs[i].exp_data});
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0;
      chk("t_refetch_req", 32'(mem_req), 32'd1);
      chk("t_refetch_addr", 32'(mem_addr), 32'(PC_W'(32'(vecs[i].pc) + 1)));
      chk("t_refetch_valid", 32'(ir_valid), 32'd0);
    end

    // Zero-latency stream: addresses 0..3, one instruction per two cycles
    pc_base = 9'h000; pc_auto = 1'b1; mem_on = 1'b1; mem_lat = 0;
    do_reset();
    for (int a = 0; a < 4; a++) sb.push_back('{PC_W'(a), 16'hA5A5 ^ 16'(a)});
    ir_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k % 2 == 1) begin
        chk("s_req", 32'(mem_req), 32'd1);
        chk("s_addr", 32'(mem_addr), 32'((k - 1) / 2));
        chk("s_pc_inc", 32'(pc_inc), 32'd1);
      end else begin
        chk("s_valid", 32'(ir_valid), 32'd1);
      end
    end
    mem_on = 1'b0;
    step();
    ir_ready = 1'b0;
    chk("s_sb_drained", 32'(sb.size()), 32'd0);
    chk("s_inc_count", 32'(inc_total - inc_base), 32'd4);
    chk("s_next_addr", 32'(mem_addr), 32'd4);

    // Flush in REQ cycle 2, ack in cycle 4: data dropped, refetch from new PC
    pc_base = 9'h010; pc_auto = 1'b0; mem_on = 1'b1; mem_lat = 3;
    do_reset();
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("f_req_held", 32'(mem_req), 32'd1);
    step();
    chk("f_no_pc_inc", 32'(pc_inc), 32'd0);
    pc_base = 9'h040;
    step();
    chk("f_idle_req", 32'(mem_req), 32'd0);
    chk("f_idle_valid", 32'(ir_valid), 32'd0);
    chk("f_inc_count", 32'(inc_total - inc_base), 32'd0);
    step();
    chk("f_new_req", 32'(mem_req), 32'd1);
    chk("f_new_addr", 32'(mem_addr), 32'h040);
    sb.push_back('{9'h040, 16'hA5E5});
    ir_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    ir_ready = 1'b0;
    chk("f_refetch_done", 32'(sb.size()), 32'd0);

    // Timeout: no ack through REQ cycle 15
    pc_base = 9'h055; pc_auto = 1'b0; mem_on = 1'b0;
    do_reset();
    repeat (15) step();
    chk("to_not_yet", 32'(halted), 32'd0);
    chk("to_req_c15", 32'(mem_req), 32'd1);
    step();
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_err", 32'(err_code), 32'(ERR_TIMEOUT));
    chk("to_req_off", 32'(mem_req), 32'd0);
    mem_on = 1'b1;
    repeat (3) step();
    chk("to_sticky", 32'({halted, err_code}), 32'({1'b1, ERR_TIMEOUT}));

    // pc_err during HOLD, then reset
    pc_base = 9'h0AA; pc_auto = 1'b1; mem_on = 1'b1; mem_lat = 0;
    do_reset();
    step();
    step();
    chk("pe_in_hold", 32'(ir_valid), 32'd1);
    pc_err = 1'b1;
    step();
    pc_err = 1'b0;
    chk("pe_halted", 32'(halted), 32'd1);
    chk("pe_err", 32'(err_code), 32'(ERR_PC));
    chk("pe_valid", 32'(ir_valid), 32'd0);
    rst = 1'b1;
    step();
    chk("pe_rst_outs", 32'({mem_req, ir_valid, halted, err_code, pc_inc}), 32'd0);
    chk("pe_rst_addr", 32'(mem_addr), 32'd0);
    chk("pe_rst_word", 32'({ir_pc, ir_data}), 32'd0);
    rst = 1'b0;

    // pc_err together with an ack: ack discarded, no pc_inc
    do_reset();
    step();
    pc_err = 1'b1;
    #1;
    chk("pa_no_pc_inc", 32'(pc_inc), 32'd0);
    step();
    pc_err = 1'b0;
    chk("pa_halted", 32'({halted, err_code}), 32'({1'b1, ERR_PC}));
    chk("pa_valid", 32'(ir_valid), 32'd0);
    chk("pa_inc_count", 32'(inc_total - inc_base), 32'd0);

    chk("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
